// File: rtl/nvram_ioctl_pkg.sv
// Shared types and constants for the NVRAM ioctl host model.
package nvram_ioctl_pkg;

  localparam int unsigned NvramIndex = 4;

  typedef enum logic [3:0] {
    StIdle,
    StDlSetup,
    StDlWr,
    StDlGap,
    StDlEnd,
    StUlSetup,
    StUlWait,
    StUlCap,
    StUlEnd
  } state_e;

endpackage

// File: rtl/nvram_ioctl_buf.sv
// Image buffer: one synchronous write port, two asynchronous read ports.
module nvram_ioctl_buf #(
  parameter int unsigned AW = 6
) (
  input  logic          clk_sys,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [7:0]    o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [7:0]    o_rdata_b
);

  localparam int unsigned Depth = 2 ** AW;

  // Deliberately unreset: the image must survive a reset.
  logic [7:0] r_mem [Depth];

  always_ff @(posedge clk_sys) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/nvram_ioctl_host.sv
// Host-side ioctl initiator: downloads the local NVRAM image into the core and
// uploads it back, servicing autosave requests and honouring ioctl_wait.
module nvram_ioctl_host
  import nvram_ioctl_pkg::*;
#(
  parameter int unsigned DUMPWIDTH = 6,
  parameter int unsigned DUMPINDEX = NvramIndex,
  parameter int unsigned WR_GAP    = 3,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 start_download,
  input  logic                 start_upload,
  output logic                 busy,
  output logic                 done,
  input  logic [DUMPWIDTH-1:0] buf_addr,
  input  logic                 buf_we,
  input  logic [7:0]           buf_wdata,
  output logic [7:0]           buf_rdata,
  output logic                 ioctl_download,
  output logic                 ioctl_upload,
  input  logic                 ioctl_upload_req,
  output logic                 ioctl_wr,
  output logic [24:0]          ioctl_addr,
  output logic [7:0]           ioctl_dout,
  input  logic [7:0]           ioctl_din,
  output logic [7:0]           ioctl_index,
  input  logic                 ioctl_wait
);

  localparam logic [DUMPWIDTH-1:0] LastAddr = '1;

  state_e               r_state, w_state_d;
  logic [DUMPWIDTH-1:0] r_addr, w_addr_d;
  logic [7:0]           r_cnt, w_cnt_d;
  logic                 r_req_q;
  logic                 r_pending, w_pending_d;
  logic                 w_req_pend;
  logic                 w_fsm_we;
  logic                 w_we;
  logic [DUMPWIDTH-1:0] w_waddr;
  logic [7:0]           w_wdata;
  logic [7:0]           w_fsm_rdata;

  // Includes a same-cycle rising edge so an idle host reacts immediately.
  assign w_req_pend = r_pending | (ioctl_upload_req & ~r_req_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_req_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_cnt     <= w_cnt_d;
      r_req_q   <= ioctl_upload_req;
      r_pending <= w_pending_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_cnt_d     = r_cnt;
    w_pending_d = w_req_pend;
    case (r_state)
      StIdle: begin
        if (start_download) begin
          w_state_d = StDlSetup;
          w_addr_d  = '0;
          w_cnt_d   = '0;
        end else if (start_upload || w_req_pend) begin
          w_state_d   = StUlSetup;
          w_addr_d    = '0;
          w_cnt_d     = '0;
          w_pending_d = 1'b0;
        end
      end
      StDlSetup: w_state_d = StDlWr;
      StDlWr: begin
        if (!ioctl_wait) begin
          w_state_d = StDlGap;
          w_cnt_d   = '0;
        end
      end
      StDlGap: begin
        if (r_cnt == 8'(WR_GAP - 1)) begin
          w_cnt_d = '0;
          if (r_addr == LastAddr) begin
            w_state_d = StDlEnd;
          end else begin
            w_addr_d  = r_addr + 1'b1;
            w_state_d = StDlWr;
          end
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StDlEnd: w_state_d = StIdle;
      StUlSetup: begin
        w_state_d = StUlWait;
        w_cnt_d   = '0;
      end
      StUlWait: begin
        // Latency count is frozen while the core stalls.
        if (!ioctl_wait) begin
          if (r_cnt == 8'(RD_LAT - 1)) begin
            w_cnt_d   = '0;
            w_state_d = StUlCap;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end
      end
      StUlCap: begin
        if (r_addr == LastAddr) begin
          w_state_d = StUlEnd;
        end else begin
          w_addr_d  = r_addr + 1'b1;
          w_state_d = StUlWait;
        end
      end
      StUlEnd: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StDlEnd) || (r_state == StUlEnd);
  assign ioctl_download = (r_state == StDlSetup) || (r_state == StDlWr) || (r_state == StDlGap);
  assign ioctl_upload   = (r_state == StUlSetup) || (r_state == StUlWait) || (r_state == StUlCap);
  assign ioctl_wr       = (r_state == StDlWr) && !ioctl_wait;
  assign ioctl_addr     = (ioctl_download || ioctl_upload) ? 25'(r_addr) : 25'd0;
  assign ioctl_index    = (ioctl_download || ioctl_upload) ? 8'(DUMPINDEX) : 8'd0;
  assign ioctl_dout     = ioctl_download ? w_fsm_rdata : 8'd0;

  // FSM capture owns the write port; bench writes are dropped while busy.
  assign w_fsm_we = (r_state == StUlCap);
  assign w_we     = w_fsm_we || (buf_we && !busy);
  assign w_waddr  = w_fsm_we ? r_addr : buf_addr;
  assign w_wdata  = w_fsm_we ? ioctl_din : buf_wdata;

  nvram_ioctl_buf #(
    .AW(DUMPWIDTH)
  ) u_buf (
    .clk_sys  (clk_sys),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr_a(buf_addr),
    .o_rdata_a(buf_rdata),
    .i_raddr_b(r_addr),
    .o_rdata_b(w_fsm_rdata)
  );

endmodule

// File: tb/tb_nvram_ioctl_host.sv
// Directed bench for nvram_ioctl_host with a 2-cycle-latency core read model.
module tb_nvram_ioctl_host;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start_download, start_upload;
  logic        busy, done;
  logic [5:0]  buf_addr;
  logic        buf_we;
  logic [7:0]  buf_wdata, buf_rdata;
  logic        ioctl_download, ioctl_upload, ioctl_upload_req, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_din, ioctl_index;
  logic        ioctl_wait;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl_host dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .start_download  (start_download),
    .start_upload    (start_upload),
    .busy            (busy),
    .done            (done),
    .buf_addr        (buf_addr),
    .buf_we          (buf_we),
    .buf_wdata       (buf_wdata),
    .buf_rdata       (buf_rdata),
    .ioctl_download  (ioctl_download),
    .ioctl_upload    (ioctl_upload),
    .ioctl_upload_req(ioctl_upload_req),
    .ioctl_wr        (ioctl_wr),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_din       (ioctl_din),
    .ioctl_index     (ioctl_index),
    .ioctl_wait      (ioctl_wait)
  );

  // Core read model: din = ~addr, two cycles behind the address.
  logic [7:0] core_d1, core_d2;
  always @(posedge clk_sys) begin
    core_d1 <= ~ioctl_addr[7:0];
    core_d2 <= core_d1;
  end
  assign ioctl_din = core_d2;

  int          cyc = 0;
  logic        prev_wr = 1'b0;
  int          b2b_cnt = 0;
  int          wr_in_wait = 0;
  logic [24:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (ioctl_wr) begin
      wr_addr_q.push_back(ioctl_addr);
      wr_data_q.push_back(ioctl_dout);
      wr_cyc_q.push_back(cyc);
      if (prev_wr) b2b_cnt <= b2b_cnt + 1;
      if (ioctl_wait) wr_in_wait <= wr_in_wait + 1;
    end
    prev_wr <= ioctl_wr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_buf(input logic [7:0] pat);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_sys);
      buf_addr  = 6'(i);
      buf_wdata = 8'(i) ^ pat;
      buf_we    = 1'b1;
    end
    @(negedge clk_sys);
    buf_we = 1'b0;
  endtask

  task automatic pulse_cmd(input logic dl, input logic ul);
    @(negedge clk_sys);
    start_download = dl;
    start_upload   = ul;
    @(posedge clk_sys);
    #1;
    start_download = 1'b0;
    start_upload   = 1'b0;
  endtask

  // Counts busy cycles from the first one after the accepted command.
  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!done && n < max);
  endtask

  function automatic int count_bad_buf(input logic [7:0] pat, input int lo, input int hi,
                                       input logic inv);
    // Unused helper; buffer reads happen in read_bad below.
    return lo + hi + int'(pat) + int'(inv);
  endfunction

  task automatic read_bad(input int lo, input int hi, input logic inv, input logic [7:0] pat,
                          output int bad);
    logic [7:0] exp;
    bad = 0;
    for (int i = lo; i <= hi; i++) begin
      buf_addr = 6'(i);
      #1;
      exp = inv ? ~8'(i) : (8'(i) ^ pat);
      if (buf_rdata !== exp) bad++;
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  int n, gap, bad, bad_a, bad_d, bad_g, hits17, dl_seen, done_seen;
  logic [7:0] pat;

  initial begin
    reset_n = 1'b0;
    start_download = 1'b0;
    start_upload = 1'b0;
    buf_addr = '0;
    buf_we = 1'b0;
    buf_wdata = '0;
    ioctl_upload_req = 1'b0;
    ioctl_wait = 1'b0;
    pat = 8'h5A;

    repeat (3) @(negedge clk_sys);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dl_ul_wr", {29'd0, ioctl_download, ioctl_upload, ioctl_wr}, 32'd0);
    check_eq("rst_addr", 32'(ioctl_addr), 32'd0);
    check_eq("rst_index_dout", {16'd0, ioctl_index, ioctl_dout}, 32'd0);
    reset_n = 1'b1;

    // 1: plain download of buf[i] = i ^ 5A.
    fill_buf(pat);
    clear_log();
    pulse_cmd(1'b1, 1'b0);
    check_eq("dl_window", 32'(ioctl_download), 32'd1);
    check_eq("dl_index", 32'(ioctl_index), 32'd4);
    wait_done(600, n);
    check_eq("dl_len", 32'(n), 32'd258);
    check_eq("dl_nwr", 32'(wr_addr_q.size()), 32'd64);
    bad_a = 0; bad_d = 0; bad_g = 0;
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      if (wr_addr_q[k] !== 25'(k)) bad_a++;
      if (wr_data_q[k] !== (8'(k) ^ pat)) bad_d++;
      if (k > 0 && (wr_cyc_q[k] - wr_cyc_q[k-1]) != 4) bad_g++;
    end
    check_eq("dl_addr_seq", 32'(bad_a), 32'd0);
    check_eq("dl_data", 32'(bad_d), 32'd0);
    check_eq("dl_spacing", 32'(bad_g), 32'd0);
    @(negedge clk_sys);
    check_eq("dl_idle_after", {30'd0, busy, ioctl_download}, 32'd0);

    // 2: upload; core returns ~addr.
    pulse_cmd(1'b0, 1'b1);
    check_eq("ul_window", 32'(ioctl_upload), 32'd1);
    wait_done(600, n);
    check_eq("ul_len", 32'(n), 32'd194);
    @(negedge clk_sys);
    read_bad(0, 63, 1'b1, pat, bad);
    check_eq("ul_data", 32'(bad), 32'd0);
    buf_addr = 6'd63;
    #1;
    check_eq("ul_byte63", 32'(buf_rdata), 32'hC0);

    // 3: stall 10 cycles at download address 17 (buffer now holds ~i).
    clear_log();
    pulse_cmd(1'b1, 1'b0);
    fork
      wait_done(600, n);
      begin
        for (int k = 0; k < 400; k++) begin
          if (ioctl_download && ioctl_addr == 25'd17) break;
          @(posedge clk_sys);
          #1;
        end
        ioctl_wait = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1;
        ioctl_wait = 1'b0;
      end
    join
    check_eq("wait_len", 32'(n), 32'd268);
    hits17 = 0;
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      if (wr_addr_q[k] == 25'd17) begin
        hits17++;
        check_eq("wait_data17", 32'(wr_data_q[k]), 32'hEE);
      end
    end
    check_eq("wait_hits17", 32'(hits17), 32'd1);
    check_eq("wait_nwr", 32'(wr_addr_q.size()), 32'd64);
    check_eq("wait_no_strobe", 32'(wr_in_wait), 32'd0);

    // 4: autosave request during download; later start_download is ignored.
    pulse_cmd(1'b1, 1'b0);
    repeat (20) @(negedge clk_sys);
    ioctl_upload_req = 1'b1;
    @(negedge clk_sys);
    ioctl_upload_req = 1'b0;
    wait_done(600, n);
    check_eq("req_dl_len", 32'(n + 21), 32'd258);
    gap = 0;
    do begin
      @(negedge clk_sys);
      gap++;
    end while (!ioctl_upload && gap < 10);
    check_eq("req_ul_gap", 32'(gap), 32'd2);
    n = 1;
    dl_seen = 0;
    while (!done && n < 400) begin
      if (n == 50) start_download = 1'b1;
      @(negedge clk_sys);
      start_download = 1'b0;
      n++;
      if (ioctl_download) dl_seen++;
    end
    check_eq("req_ul_len", 32'(n), 32'd194);
    repeat (5) begin
      @(negedge clk_sys);
      if (ioctl_download || busy) dl_seen++;
    end
    check_eq("req_dl_ignored", 32'(dl_seen), 32'd0);

    // 5: simultaneous commands -> download only.
    pulse_cmd(1'b1, 1'b1);
    check_eq("both_dl", {30'd0, ioctl_download, ioctl_upload}, 32'd2);
    wait_done(600, n);
    check_eq("both_len", 32'(n), 32'd258);
    repeat (10) @(negedge clk_sys);
    check_eq("both_no_ul", {30'd0, busy, ioctl_upload}, 32'd0);

    // 6: reset while waiting on upload byte 30.
    fill_buf(pat);
    pulse_cmd(1'b0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_sys);
      if (ioctl_upload && ioctl_addr == 25'd30) break;
    end
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_drop", {29'd0, ioctl_upload, busy, done}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (done) done_seen++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk_sys);
      if (done) done_seen++;
    end
    check_eq("rstmid_no_done", 32'(done_seen), 32'd0);
    read_bad(0, 29, 1'b1, pat, bad);
    check_eq("rstmid_captured", 32'(bad), 32'd0);
    read_bad(30, 63, 1'b0, pat, bad);
    check_eq("rstmid_untouched", 32'(bad), 32'd0);
    check_eq("b2b_strobes", 32'(b2b_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
